// File: rtl/seg_memory_access_sized.sv
// MEM pipeline stage: sized, byte-enabled data memory, misalignment detection,
// BEQ/BNE resolution and the MEM/WB register with stall and flush.
module seg_memory_access_sized #(
    parameter int unsigned LEN        = 32,
    parameter int unsigned NB_ADDR    = 5,
    parameter int unsigned NB_CTRL_WB = 2,
    parameter int unsigned NB_CTRL_M  = 4,
    parameter int unsigned RAM_DEPTH  = 2048,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [LEN-1:0]        i_PC_branch,
    input  logic [LEN-1:0]        i_ALU_result,
    input  logic                  i_ALU_zero,
    input  logic [LEN-1:0]        i_write_data,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic [1:0]            i_mem_size,
    input  logic                  i_mem_unsigned,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    output logic                  o_PCSrc,
    output logic [LEN-1:0]        o_PC_branch,
    output logic                  o_misaligned,
    output logic [LEN-1:0]        o_read_data,
    output logic [LEN-1:0]        o_address,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus
);

    localparam int unsigned IDX_W  = $clog2(RAM_DEPTH);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NB_BE  = WORD_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic branch, branch_ne, mem_read, mem_write;
    logic [1:0]            off;
    logic [IDX_W-1:0]      widx;
    logic                  misaligned_c;
    logic [NB_BE-1:0]      be;
    logic [WORD_W-1:0]     wdata;
    logic                  ram_re;
    logic [NB_CTRL_WB-1:0] ctrl_wb_next;

    logic [WORD_W-1:0]     mem [RAM_DEPTH];
    logic [WORD_W-1:0]     ram_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic                  uns_q;
    logic [WORD_W-1:0]     lane;
    logic [WORD_W-1:0]     ext;

    assign branch    = i_ctrl_mem_bus[NB_CTRL_M-1];
    assign branch_ne = i_ctrl_mem_bus[NB_CTRL_M-2];
    assign mem_read  = i_ctrl_mem_bus[NB_CTRL_M-3];
    assign mem_write = i_ctrl_mem_bus[NB_CTRL_M-4];

    assign off  = i_ALU_result[1:0];
    assign widx = i_ALU_result[IDX_W+1:2];

    assign o_PCSrc     = branch & (i_ALU_zero ^ branch_ne);
    assign o_PC_branch = i_PC_branch;

    // Alignment fault only matters for real memory accesses.
    always_comb begin
        misaligned_c = 1'b0;
        if (mem_read || mem_write) begin
            case (i_mem_size)
                SZ_BYTE: misaligned_c = 1'b0;
                SZ_HALF: misaligned_c = off[0];
                default: misaligned_c = (off != 2'b00);
            endcase
        end
    end

    // Byte lanes and replicated store data; any blocking condition kills the write.
    always_comb begin
        be    = '0;
        wdata = i_write_data[WORD_W-1:0];
        case (i_mem_size)
            SZ_BYTE: begin
                be    = NB_BE'(4'b0001 << off);
                wdata = {4{i_write_data[7:0]}};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_write_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
        if (!mem_write || misaligned_c || i_flush || i_stall || i_rst) begin
            be = '0;
        end
    end

    assign ram_re = mem_read & ~misaligned_c & ~i_stall & ~i_flush;

    always_comb begin
        ctrl_wb_next = i_ctrl_wb_bus;
        if (misaligned_c) begin
            ctrl_wb_next[NB_CTRL_WB-1] = 1'b0;
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < int'(NB_BE); b++) begin
            if (be[b]) begin
                mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // MEM/WB register and synchronous RAM read port: rst > stall > flush > load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_address        <= '0;
            o_write_register <= '0;
            o_ctrl_wb_bus    <= '0;
            o_misaligned     <= 1'b0;
            ram_q            <= '0;
            size_q           <= '0;
            off_q            <= '0;
            uns_q            <= 1'b0;
        end else if (!i_stall) begin
            o_address        <= i_ALU_result;
            o_write_register <= i_write_register;
            if (i_flush) begin
                o_ctrl_wb_bus <= '0;
                o_misaligned  <= 1'b0;
            end else begin
                o_ctrl_wb_bus <= ctrl_wb_next;
                o_misaligned  <= misaligned_c;
            end
            if (ram_re) begin
                ram_q  <= mem[widx];
                size_q <= i_mem_size;
                off_q  <= off;
                uns_q  <= i_mem_unsigned;
            end
        end
    end

    // Lane select and extension of the registered read word.
    always_comb begin
        lane = ram_q >> {off_q, 3'b000};
        ext  = ram_q;
        case (size_q)
            SZ_BYTE: ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ext = ram_q;
        endcase
    end

    assign o_read_data = LEN'(ext);

endmodule

// File: tb/tb_seg_memory_access_sized.sv
// Directed bench for seg_memory_access_sized; expected MEM/WB outputs are queued
// when an instruction is presented and compared one edge later.
module tb_seg_memory_access_sized;

    localparam logic [3:0] LD = 4'b0010;
    localparam logic [3:0] ST = 4'b0001;
    localparam logic [3:0] NO = 4'b0000;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    logic        clk = 1'b0;
    logic        i_rst, i_stall, i_flush, i_ALU_zero, i_mem_unsigned;
    logic [31:0] i_PC_branch, i_ALU_result, i_write_data;
    logic [4:0]  i_write_register;
    logic [1:0]  i_mem_size, i_ctrl_wb_bus;
    logic [3:0]  i_ctrl_mem_bus;
    logic        o_PCSrc, o_misaligned;
    logic [31:0] o_PC_branch, o_read_data, o_address;
    logic [4:0]  o_write_register;
    logic [1:0]  o_ctrl_wb_bus;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic [31:0] addr;
        logic [4:0]  wreg;
        logic        chk_aw;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [4:0]  wreg_cnt = 5'd0;

    always #5 clk = ~clk;

    seg_memory_access_sized dut (
        .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_PC_branch(i_PC_branch), .i_ALU_result(i_ALU_result), .i_ALU_zero(i_ALU_zero),
        .i_write_data(i_write_data), .i_write_register(i_write_register),
        .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
        .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus),
        .o_PCSrc(o_PCSrc), .o_PC_branch(o_PC_branch), .o_misaligned(o_misaligned),
        .o_read_data(o_read_data), .o_address(o_address),
        .o_write_register(o_write_register), .o_ctrl_wb_bus(o_ctrl_wb_bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Present one instruction for one cycle, queue its MEM/WB image, compare after the edge.
    task automatic op(input string tag, input logic rst, input logic stall, input logic flush,
                      input logic [3:0] mctl, input logic [1:0] wb, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_mis, input logic chk_rd, input logic [31:0] exp_rd);
        exp_t e;
        exp_t got;
        i_rst = rst; i_stall = stall; i_flush = flush;
        i_ctrl_mem_bus = mctl; i_ctrl_wb_bus = wb; i_mem_size = size; i_mem_unsigned = uns;
        i_ALU_result = addr; i_write_data = wd; i_write_register = wreg_cnt;
        i_ALU_zero = 1'b0;
        if (rst) begin
            e = '{rd: 32'h0, chk_rd: 1'b1, addr: 32'h0, wreg: 5'h0, chk_aw: 1'b1, wb: 2'b00, mis: 1'b0};
        end else if (stall) begin
            e = last;
        end else begin
            e.addr   = addr;
            e.wreg   = wreg_cnt;
            e.chk_aw = !flush;
            e.wb     = flush ? 2'b00 : {wb[1] & !exp_mis, wb[0]};
            e.mis    = flush ? 1'b0 : exp_mis;
            e.rd     = exp_rd;
            e.chk_rd = chk_rd;
        end
        sb_q.push_back(e);
        wreg_cnt = wreg_cnt + 5'd1;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "/queue"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({tag, "/wb"}, 32'(o_ctrl_wb_bus), 32'(got.wb));
            check({tag, "/mis"}, 32'(o_misaligned), 32'(got.mis));
            if (got.chk_aw) begin
                check({tag, "/addr"}, o_address, got.addr);
                check({tag, "/wreg"}, 32'(o_write_register), 32'(got.wreg));
            end
            if (got.chk_rd) begin
                check({tag, "/rd"}, o_read_data, got.rd);
            end
        end
        last = e;
        i_rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    endtask

    // Combinational branch decision and target pass-through.
    task automatic br(input string tag, input logic b, input logic bne, input logic z,
                      input logic stall, input logic expv);
        logic [31:0] tgt;
        tgt = $urandom;
        i_ctrl_mem_bus = {b, bne, 2'b00};
        i_ALU_zero = z; i_stall = stall; i_PC_branch = tgt;
        #1;
        check({tag, "/pcsrc"}, 32'(o_PCSrc), 32'(expv));
        check({tag, "/target"}, o_PC_branch, tgt);
        i_stall = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_ALU_zero = 1'b0; i_mem_unsigned = 1'b0;
        i_PC_branch = 32'h0; i_ALU_result = 32'h0; i_write_data = 32'h0; i_write_register = 5'h0;
        i_mem_size = SW; i_ctrl_wb_bus = 2'b00; i_ctrl_mem_bus = NO;

        op("reset0", 1, 0, 0, NO, 2'b00, SW, 0, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        op("reset1", 1, 0, 0, LD, 2'b11, SW, 0, 32'h0000_0010, 32'h0, 0, 0, 32'h0);

        op("sw10",    0, 0, 0, ST, 2'b00, SW, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0);
        op("lw10",    0, 0, 0, LD, 2'b11, SW, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF);
        op("sb11",    0, 0, 0, ST, 2'b00, SB, 0, 32'h11, 32'h0000_0080, 0, 0, 32'h0);
        op("lb11",    0, 0, 0, LD, 2'b11, SB, 0, 32'h11, 32'h0, 0, 1, 32'hFFFF_FF80);
        op("lbu11",   0, 0, 0, LD, 2'b11, SB, 1, 32'h11, 32'h0, 0, 1, 32'h0000_0080);
        op("lw10b",   0, 0, 0, LD, 2'b11, SW, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_80EF);
        op("sh12a",   0, 0, 0, ST, 2'b00, SH, 0, 32'h12, 32'h0000_1234, 0, 0, 32'h0);
        op("lh12a",   0, 0, 0, LD, 2'b11, SH, 0, 32'h12, 32'h0, 0, 1, 32'h0000_1234);
        op("sh12b",   0, 0, 0, ST, 2'b00, SH, 0, 32'h12, 32'h0000_8001, 0, 0, 32'h0);
        op("lh12b",   0, 0, 0, LD, 2'b11, SH, 0, 32'h12, 32'h0, 0, 1, 32'hFFFF_8001);
        op("lhu12",   0, 0, 0, LD, 2'b11, SH, 1, 32'h12, 32'h0, 0, 1, 32'h0000_8001);
        op("lb10s",   0, 0, 0, LD, 2'b11, SB, 0, 32'h10, 32'h0, 0, 1, 32'hFFFF_FFEF);

        op("lw11mis", 0, 0, 0, LD, 2'b11, SW, 0, 32'h11, 32'h0, 1, 0, 32'h0);
        op("sh13mis", 0, 0, 0, ST, 2'b00, SH, 0, 32'h13, 32'h0000_FFFF, 1, 0, 32'h0);
        op("lw10c",   0, 0, 0, LD, 2'b11, SW, 0, 32'h10, 32'h0, 0, 1, 32'h8001_80EF);
        op("nomem13", 0, 0, 0, NO, 2'b10, SW, 0, 32'h13, 32'h0, 0, 0, 32'h0);
        op("lrsv10",  0, 0, 0, LD, 2'b11, SR, 0, 32'h10, 32'h0, 0, 1, 32'h8001_80EF);
        op("lrsv12",  0, 0, 0, LD, 2'b11, SR, 0, 32'h12, 32'h0, 1, 0, 32'h0);

        op("sw14",    0, 0, 0, ST, 2'b00, SW, 0, 32'h14, 32'h0BAD_F00D, 0, 0, 32'h0);
        op("lw10d",   0, 0, 0, LD, 2'b11, SW, 0, 32'h10, 32'h0, 0, 1, 32'h8001_80EF);
        for (int i = 0; i < 3; i++) begin
            op("lw14stl", 0, 1, 0, LD, 2'b11, SW, 0, 32'h14, 32'h0, 0, 0, 32'h0);
        end
        op("lw14rel", 0, 0, 0, LD, 2'b11, SW, 0, 32'h14, 32'h0, 0, 1, 32'h0BAD_F00D);

        op("sw18",    0, 0, 0, ST, 2'b00, SW, 0, 32'h18, 32'h1111_2222, 0, 0, 32'h0);
        op("sw18stl", 0, 1, 0, ST, 2'b00, SW, 0, 32'h18, 32'h3333_4444, 0, 0, 32'h0);
        op("lw18a",   0, 0, 0, LD, 2'b11, SW, 0, 32'h18, 32'h0, 0, 1, 32'h1111_2222);
        op("sw18fl",  0, 0, 1, ST, 2'b01, SW, 0, 32'h18, 32'h5555_6666, 0, 0, 32'h0);
        op("lw18b",   0, 0, 0, LD, 2'b11, SW, 0, 32'h18, 32'h0, 0, 1, 32'h1111_2222);
        op("lw11fl",  0, 0, 1, LD, 2'b11, SW, 0, 32'h11, 32'h0, 0, 0, 32'h0);
        op("sw18rst", 1, 1, 0, ST, 2'b00, SW, 0, 32'h18, 32'h7777_7777, 0, 0, 32'h0);
        op("lw18c",   0, 0, 0, LD, 2'b11, SW, 0, 32'h18, 32'h0, 0, 1, 32'h1111_2222);
        op("lw18rst", 1, 0, 0, LD, 2'b11, SW, 0, 32'h18, 32'h0, 0, 0, 32'h0);

        op("swwrap",  0, 0, 0, ST, 2'b00, SW, 0, 32'h0000_2010, 32'hA5A5_5A5A, 0, 0, 32'h0);
        op("lwwrap",  0, 0, 0, LD, 2'b11, SW, 0, 32'h0000_0010, 32'h0, 0, 1, 32'hA5A5_5A5A);

        br("beq_t",  1, 0, 1, 0, 1);
        br("bne_nt", 1, 1, 1, 0, 0);
        br("bne_t",  1, 1, 0, 1, 1);
        br("beq_nt", 1, 0, 0, 0, 0);
        br("nobr_z", 0, 0, 1, 0, 0);
        br("nobr_n", 0, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
